dbgnoc_out_arbiter: RTL and testbench
=====================================

Name: dbgnoc_out_arbiter

Overview:
- Packet-aware arbiter that shares one lisnoc16 Debug NoC output link between PORTS requesters, e.g. the configuration interface and a converter datapath inside a debug module.
- Replaces ad-hoc per-module rts/cts muxing with one sequenced grant.
- Two modes:
  - Optional fixed-priority port; remaining ports served round-robin.
  - Grant held until the granted packet's last flit transfers.
- Never interleaves flits of two packets.

Parameters:
- PORTS, 2, number of requesters (2..8).
- FLIT_WIDTH, 18, lisnoc16 flit width; type field is bits [FLIT_WIDTH-1:FLIT_WIDTH-2].
- PRIO_EN, 1, 1: port PRIO_PORT wins over round-robin whenever requesting.
- PRIO_PORT, 0, index of priority port.
- IDLE_TIMEOUT, 15, cycles a grant survives with no flit started and no request before release (1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_flit  in  PORTS*FLIT_WIDTH  flattened requester flits; port i at [(i+1)*FLIT_WIDTH-1:i*FLIT_WIDTH].
- in_valid  in  PORTS  per-port flit valid.
- in_ready  out  PORTS  per-port flit accept.
- in_rts  in  PORTS  per-port request-to-send (may precede valid).
- in_cts  out  PORTS  per-port clear-to-send (registered grant, one-hot or zero).
- out_flit  out  FLIT_WIDTH  Debug NoC flit.
- out_valid  out  1  Debug NoC valid.
- out_ready  in  1  Debug NoC ready.
- busy  out  1  high while a grant is held.

Behaviour:
- Flit types (lisnoc16):
  - 01 header
  - 00 payload
  - 10 last
  - 11 single
  - Packet ends on transfer of type 10 or 11.
- Transfer = out_valid & out_ready.
- Request of port i: req[i] = in_rts[i] | in_valid[i].
- States:
  - IDLE:
    - If any req, pick winner w and go to LOCKED at the next edge; in_cts[w] <= 1 on that edge.
    - Arbitration latency 1 cycle; no flit passes in IDLE.
  - LOCKED(g):
    - out_flit = in_flit[g], out_valid = in_valid[g], in_ready[g] = out_ready; all other in_ready = 0. These paths are combinational, no extra latency.
    - On transfer of last/single: next edge -> IDLE, in_cts <= 0, rr pointer <= g (only if g is not the priority port).
    - Back-to-back packets from the same port therefore cost one idle cycle.
- Winner selection:
  - If PRIO_EN and req[PRIO_PORT], w = PRIO_PORT.
  - Otherwise, first requesting port scanning ptr+1, ptr+2, … modulo PORTS, skipping PRIO_PORT when PRIO_EN.
- Idle timeout:
  - In LOCKED with no flit of the current packet yet transferred, count cycles where req[g] = 0.
  - Counter resets on any req[g] = 1 cycle.
  - Reaching IDLE_TIMEOUT releases to IDLE without a transfer. Pointer is not advanced.
  - Once the header has transferred, no timeout applies: the packet must complete.
- Headerless start: a granted port whose first flit is payload/last is forwarded unmodified; no type checking.
- Simultaneous events:
  - A new request arriving in the same cycle as the last-flit transfer is arbitrated in the following IDLE cycle.
  - rts dropping mid-packet does not release the grant.
- Outputs in IDLE: out_valid = 0, out_flit = 0, in_ready = 0, busy = 0. busy = 1 in LOCKED.
- Reset: state IDLE, in_cts = 0, ptr = PORTS-1 (so port 0 is first round-robin candidate), timeout counter 0, out_valid = 0, in_ready = 0.
  - Reset mid-packet aborts the grant; the downstream packet is left truncated. This is acceptable, as system reset also resets the Debug NoC.

Test Plan:
1. Reset, then in_rts[1] = 1 with single flit 0x3_0042 valid on port 1 -> in_cts = 2'b10 one cycle later; out_flit = 0x3_0042 transfers; next cycle in_cts = 0, busy = 0.
2. PORTS = 3, PRIO_EN = 0, all ports requesting continuously with 2-flit packets (01,10) -> grant order 0,1,2,0,1,2; no interleaving on out_flit.
3. PRIO_EN = 1, PRIO_PORT = 0; port 1 mid-packet (header sent), port 0 raises rts -> port 1 completes its last flit first; port 0 granted in the next arbitration; port 2 waits.
4. Port 1 granted by rts only, never asserts valid, IDLE_TIMEOUT = 4 -> released to IDLE after 4 cycles; ptr unchanged, so port 1 wins again if still requesting.
5. out_ready held 0 for 10 cycles during a 4-flit packet -> out_valid stays 1, flit stable, in_ready[g] = 0; no timeout release.
6. Assert rst for one cycle mid-packet -> next cycle in_cts = 0, out_valid = 0, in_ready = 0, busy = 0.

Source files
------------

// File: rtl/dbgnoc_out_arbiter.sv
// Packet-aware arbiter sharing one lisnoc16 Debug NoC output link between
// PORTS requesters. A grant is held from arbitration until the last/single
// flit of the granted packet transfers, so packets never interleave. An
// optional priority port beats the round-robin set; a grant that never
// starts a packet is released after IDLE_TIMEOUT quiet cycles.
module dbgnoc_out_arbiter #(
   parameter int PORTS        = 2,
   parameter int FLIT_WIDTH   = 18,
   parameter int PRIO_EN      = 1,
   parameter int PRIO_PORT    = 0,
   parameter int IDLE_TIMEOUT = 15
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [PORTS*FLIT_WIDTH-1:0] in_flit,
   input  logic [PORTS-1:0]            in_valid,
   output logic [PORTS-1:0]            in_ready,
   input  logic [PORTS-1:0]            in_rts,
   output logic [PORTS-1:0]            in_cts,
   output logic [FLIT_WIDTH-1:0]       out_flit,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy
);

   localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                             state;
   logic [IW-1:0]                      gnt;       // granted port while LOCKED
   logic [IW-1:0]                      ptr;       // last round-robin port served
   logic [IW-1:0]                      win;
   logic [7:0]                         idle_cnt;
   logic                               started;   // a flit of this grant has moved
   logic [PORTS-1:0]                   cts;
   logic [PORTS-1:0][FLIT_WIDTH-1:0]   flits;
   logic [PORTS-1:0]                   req;
   logic                               locked;
   logic                               xfer;
   logic                               last_xfer;

   assign flits  = in_flit;
   assign req    = in_rts | in_valid;
   assign locked = (state == LOCKED);

   // Winner: priority port if enabled and requesting, else first requester
   // after ptr. Scanning k downwards lets the smallest offset win.
   always_comb begin : win_sel
      int idx;
      idx = 0;
      win = '0;
      for (int k = PORTS; k >= 1; k--) begin
         idx = (int'(ptr) + k) % PORTS;
         if (req[idx] && !(PRIO_EN != 0 && idx == PRIO_PORT))
            win = IW'(idx);
      end
      if (PRIO_EN != 0 && req[PRIO_PORT])
         win = IW'(PRIO_PORT);
   end

   // Datapath follows the grant combinationally; zero when idle.
   assign out_valid = locked & in_valid[gnt];
   assign out_flit  = locked ? flits[gnt] : '0;
   assign xfer      = out_valid & out_ready;
   // Types 10 (last) and 11 (single) both have the top type bit set.
   assign last_xfer = xfer & out_flit[FLIT_WIDTH-1];
   assign busy      = locked;
   assign in_cts    = cts;

   // Only the granted port sees the downstream ready.
   always_comb begin
      in_ready = '0;
      if (locked)
         in_ready[gnt] = out_ready;
   end

   // Grant FSM: arbitrate in IDLE, hold until end of packet or idle timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         ptr      <= IW'(PORTS - 1);
         cts      <= '0;
         idle_cnt <= '0;
         started  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               idle_cnt <= '0;
               started  <= 1'b0;
               if (|req) begin
                  state <= LOCKED;
                  gnt   <= win;
                  cts   <= PORTS'(1) << win;
               end
            end
            LOCKED: begin
               if (last_xfer) begin
                  state <= IDLE;
                  cts   <= '0;
                  if (!(PRIO_EN != 0 && int'(gnt) == PRIO_PORT))
                     ptr <= gnt;
               end else if (xfer) begin
                  started <= 1'b1;
               end else if (!started) begin
                  // Timeout only guards grants that never started a packet;
                  // release does not move the round-robin pointer.
                  if (req[gnt]) begin
                     idle_cnt <= '0;
                  end else if (idle_cnt == 8'(IDLE_TIMEOUT - 1)) begin
                     state <= IDLE;
                     cts   <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dbgnoc_out_arbiter.sv
// Bench for dbgnoc_out_arbiter: directed scenarios plus a randomized phase,
// all compared every cycle against a packet-level reference model.
module tb_dbgnoc_out_arbiter;

   localparam int P  = 3;
   localparam int W  = 18;
   localparam int TO = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [P*W-1:0]   in_flit;
   logic [P-1:0]     in_valid, in_ready, in_rts, in_cts;
   logic [W-1:0]     out_flit;
   logic             out_valid, out_ready, busy;

   always #5 clk = ~clk;

   dbgnoc_out_arbiter #(
      .PORTS(P), .FLIT_WIDTH(W), .PRIO_EN(1), .PRIO_PORT(0), .IDLE_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
      .in_ready(in_ready), .in_rts(in_rts), .in_cts(in_cts),
      .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy)
   );

   int n_pass = 0, n_fail = 0, n_chk = 0;

   // Source side: per-port flit queues and request behaviour knobs.
   logic [W-1:0] fq [P][$];
   logic [P-1:0] rts_force = '0;
   bit           rts_auto = 1'b1, gap_en = 1'b0, rdy_rand = 1'b0, rdy_fix = 1'b1;

   // Reference model: who owns the link, who was served last, quiet cycles.
   int m_owner = -1, m_last = P - 1, m_quiet = 0;
   bit m_sent = 1'b0;

   // Observed DUT behaviour: grant order and transferred flits.
   int           dgr[$];
   logic [W-1:0] dout[$];
   logic [P-1:0] cts_prev = '0;

   task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      assert (act === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic int gr(input int k);
      return (dgr.size() > k) ? dgr[k] : -1;
   endfunction

   // Priority port 0 first, then the ports after the last served one.
   function automatic int pick(input logic [P-1:0] req);
      if (req[0]) return 0;
      for (int k = 1; k <= P; k++) begin
         int c;
         c = (m_last + k) % P;
         if (c != 0 && req[c]) return c;
      end
      return -1;
   endfunction

   task automatic pkt(input int port, input int len, input bit hdrless);
      for (int j = 0; j < len; j++) begin
         logic [1:0] t;
         if (len == 1)         t = hdrless ? 2'b10 : 2'b11;
         else if (j == 0)      t = hdrless ? 2'b00 : 2'b01;
         else if (j == len-1)  t = 2'b10;
         else                  t = 2'b00;
         fq[port].push_back({t, 16'($urandom)});
      end
   endtask

   task automatic drive();
      for (int i = 0; i < P; i++) begin
         bit has;
         has = fq[i].size() > 0;
         in_valid[i] = has && !(gap_en && $urandom_range(3) == 0);
         in_flit[i*W +: W] = has ? fq[i][0] : W'($urandom);
         in_rts[i] = rts_force[i] | (rts_auto && has && (!gap_en || $urandom_range(1) == 1));
      end
      out_ready = rdy_rand ? 1'($urandom_range(1)) : rdy_fix;
   endtask

   task automatic check_outputs();
      logic [P-1:0] ecs, erdy;
      logic         eov;
      logic [W-1:0] ef;
      ecs = '0; erdy = '0; eov = 1'b0; ef = '0;
      if (m_owner >= 0) begin
         ecs[m_owner]  = 1'b1;
         erdy[m_owner] = out_ready;
         eov           = in_valid[m_owner];
         ef            = in_flit[m_owner*W +: W];
      end
      chk("in_cts", W'(in_cts), W'(ecs));
      chk("in_ready", W'(in_ready), W'(erdy));
      chk("out_valid", W'(out_valid), W'(eov));
      chk("out_flit", out_flit, ef);
      chk("busy", W'(busy), W'(m_owner >= 0));
      if (in_cts != '0 && cts_prev == '0)
         for (int i = 0; i < P; i++) if (in_cts[i]) dgr.push_back(i);
      cts_prev = in_cts;
      if (out_valid && out_ready) dout.push_back(out_flit);
   endtask

   task automatic update_model();
      logic [P-1:0] req;
      logic [W-1:0] f;
      bit           xfer;
      req = in_valid | in_rts;
      xfer = 1'b0;
      f = '0;
      if (m_owner >= 0 && in_valid[m_owner] && out_ready) begin
         xfer = 1'b1;
         f = fq[m_owner].pop_front();
      end
      if (rst) begin
         m_owner = -1; m_last = P - 1;
      end else if (m_owner < 0) begin
         m_owner = pick(req);
         m_quiet = 0;
         m_sent  = 1'b0;
      end else if (xfer) begin
         if (f[W-1]) begin
            if (m_owner != 0) m_last = m_owner;
            m_owner = -1;
         end else begin
            m_sent = 1'b1;
         end
      end else if (!m_sent) begin
         if (req[m_owner]) m_quiet = 0;
         else begin
            m_quiet++;
            if (m_quiet == TO) m_owner = -1;
         end
      end
   endtask

   task automatic cycle();
      drive();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic clear_obs();
      dgr.delete();
      dout.delete();
   endtask

   initial begin
      rst = 1'b1;
      drive();
      @(posedge clk);
      #1;
      // Reset state
      cycle();
      cycle();
      rst = 1'b0;

      // Single flit on port 1 via rts
      clear_obs();
      fq[1].push_back(18'h30042);
      repeat (4) cycle();
      chk("t1_grant", W'(gr(0)), W'(1));
      chk("t1_ngrants", W'(dgr.size()), W'(1));
      chk("t1_flit", (dout.size() > 0) ? dout[0] : 'x, 18'h30042);
      chk("t1_busy_after", W'(busy), W'(0));

      // Round robin between ports 1 and 2 (port 1 served last)
      clear_obs();
      for (int n = 0; n < 2; n++) begin
         pkt(1, 2, 1'b0);
         pkt(2, 2, 1'b0);
      end
      repeat (14) cycle();
      chk("t2_g0", W'(gr(0)), W'(2));
      chk("t2_g1", W'(gr(1)), W'(1));
      chk("t2_g2", W'(gr(2)), W'(2));
      chk("t2_g3", W'(gr(3)), W'(1));
      chk("t2_nflits", W'(dout.size()), W'(8));

      // Priority port arrives mid-packet: current packet completes first
      clear_obs();
      pkt(2, 3, 1'b0);
      pkt(1, 2, 1'b0);
      repeat (2) cycle();
      pkt(0, 1, 1'b0);
      repeat (10) cycle();
      chk("t3_g0", W'(gr(0)), W'(2));
      chk("t3_g1", W'(gr(1)), W'(0));
      chk("t3_g2", W'(gr(2)), W'(1));

      // Idle timeout, counter restart, pointer left unchanged
      clear_obs();
      rts_auto = 1'b0;
      rts_force = 3'b110;
      cycle();
      rts_force = 3'b010;
      repeat (2) cycle();
      rts_force = 3'b110;
      cycle();
      rts_force = 3'b010;
      repeat (3) cycle();
      chk("t4_still_busy", W'(busy), W'(1));
      cycle();
      chk("t4_released", W'(busy), W'(0));
      rts_force = 3'b110;
      cycle();
      rts_force = 3'b000;
      repeat (5) cycle();
      chk("t4_g0", W'(gr(0)), W'(2));
      chk("t4_g1", W'(gr(1)), W'(2));
      chk("t4_end_idle", W'(busy), W'(0));
      rts_auto = 1'b1;

      // Downstream stall during a 4-flit packet
      clear_obs();
      pkt(1, 4, 1'b0);
      repeat (2) cycle();
      rdy_fix = 1'b0;
      repeat (10) cycle();
      chk("t5_held", W'(busy), W'(1));
      chk("t5_valid", W'(out_valid), W'(1));
      chk("t5_one_sent", W'(dout.size()), W'(1));
      rdy_fix = 1'b1;
      repeat (4) cycle();
      chk("t5_all_sent", W'(dout.size()), W'(4));

      // Randomized traffic with bubbles, rts drops and backpressure
      gap_en = 1'b1;
      rdy_rand = 1'b1;
      repeat (400) begin
         for (int i = 0; i < P; i++)
            if (fq[i].size() == 0 && $urandom_range(2) == 0)
               pkt(i, $urandom_range(1, 4), $urandom_range(7) == 0);
         cycle();
      end
      gap_en = 1'b0;
      rdy_rand = 1'b0;
      repeat (60) cycle();
      for (int i = 0; i < P; i++) chk("rand_drained", W'(fq[i].size()), W'(0));

      // Reset mid-packet aborts the grant
      pkt(2, 3, 1'b0);
      repeat (2) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("t6_busy", W'(busy), W'(0));
      chk("t6_cts", W'(in_cts), W'(0));
      chk("t6_ready", W'(in_ready), W'(0));
      chk("t6_valid", W'(out_valid), W'(0));
      repeat (8) cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
